// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter sharing one APB master port among NUM_REQ
// requesters. One request in flight at a time; SETUP/ACCESS sequencing with an
// optional wait-state timeout; the response is returned to the granted requester.
module apb_master_arb #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(APB_DATA_WIDTH/8)-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]                  req_prot,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [APB_DATA_WIDTH-1:0]             rsp_rdata,
  output logic                                  rsp_error,
  output logic [APB_ADDR_WIDTH-1:0]             paddr,
  output logic                                  pwrite,
  output logic [APB_DATA_WIDTH-1:0]             pwdata,
  output logic [APB_DATA_WIDTH/8-1:0]           pstrb,
  output logic [2:0]                            pprot,
  output logic                                  psel,
  output logic                                  penable,
  input  logic [APB_DATA_WIDTH-1:0]             prdata,
  input  logic                                  pready,
  input  logic                                  pslverr
);

  localparam int unsigned AW      = APB_ADDR_WIDTH;
  localparam int unsigned DW      = APB_DATA_WIDTH;
  localparam int unsigned SW      = APB_DATA_WIDTH / 8;
  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t             r_state,      w_state_nxt;
  logic [IDX_W-1:0]   r_last_grant, w_last_grant_nxt;
  logic [IDX_W-1:0]   r_grant,      w_grant_nxt;
  logic [CNT_W-1:0]   r_wait_cnt,   w_wait_cnt_nxt;
  logic [AW-1:0]      r_paddr,      w_paddr_nxt;
  logic               r_pwrite,     w_pwrite_nxt;
  logic [DW-1:0]      r_pwdata,     w_pwdata_nxt;
  logic [SW-1:0]      r_pstrb,      w_pstrb_nxt;
  logic [2:0]         r_pprot,      w_pprot_nxt;
  logic               r_psel,       w_psel_nxt;
  logic               r_penable,    w_penable_nxt;
  logic [NUM_REQ-1:0] r_rsp_valid,  w_rsp_valid_nxt;
  logic [DW-1:0]      r_rsp_rdata,  w_rsp_rdata_nxt;
  logic               r_rsp_error,  w_rsp_error_nxt;

  logic               w_gnt_found;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [IDX_W-1:0]   w_cand;

  // Round-robin search starting one past the previous grant
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_cand = IDX_W'((32'(r_last_grant) + 32'(k)) % NUM_REQ);
      if (!w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  assign req_ready = (rstn && (r_state == S_IDLE) && w_gnt_found)
                     ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  // Next-state and next-output logic for the transfer sequencer
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_paddr_nxt      = r_paddr;
    w_pwrite_nxt     = r_pwrite;
    w_pwdata_nxt     = r_pwdata;
    w_pstrb_nxt      = r_pstrb;
    w_pprot_nxt      = r_pprot;
    w_psel_nxt       = r_psel;
    w_penable_nxt    = r_penable;
    w_rsp_valid_nxt  = '0;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_rsp_error_nxt  = r_rsp_error;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_state_nxt      = S_SETUP;
          w_last_grant_nxt = w_gnt_idx;
          w_grant_nxt      = w_gnt_idx;
          w_wait_cnt_nxt   = '0;
          w_paddr_nxt      = req_addr[w_gnt_idx*AW +: AW];
          w_pwrite_nxt     = req_write[w_gnt_idx];
          w_pwdata_nxt     = req_wdata[w_gnt_idx*DW +: DW];
          w_pstrb_nxt      = req_write[w_gnt_idx] ? req_strb[w_gnt_idx*SW +: SW] : '0;
          w_pprot_nxt      = req_prot[w_gnt_idx*3 +: 3];
          w_psel_nxt       = 1'b1;
          w_penable_nxt    = 1'b0;
        end
      end
      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          w_state_nxt     = S_IDLE;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = NUM_REQ'(1) << r_grant;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
          w_rsp_error_nxt = pslverr;
        end else if ((TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TO_LAST))) begin
          w_state_nxt     = S_IDLE;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = NUM_REQ'(1) << r_grant;
          w_rsp_rdata_nxt = '0;
          w_rsp_error_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant      <= '0;
      r_wait_cnt   <= '0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
      r_pprot      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_error  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_paddr      <= w_paddr_nxt;
      r_pwrite     <= w_pwrite_nxt;
      r_pwdata     <= w_pwdata_nxt;
      r_pstrb      <= w_pstrb_nxt;
      r_pprot      <= w_pprot_nxt;
      r_psel       <= w_psel_nxt;
      r_penable    <= w_penable_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_rsp_error  <= w_rsp_error_nxt;
    end
  end

  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign pprot     = r_pprot;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: stimulus pushes expected APB phases and
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_apb_master_arb;

  localparam logic [31:0] HANG_ADDR = 32'hBAD0_0000;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          acc;
    int          gap;
  } apb_exp_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_strb;
  logic [11:0]  req_prot;
  logic [31:0]  rsp_rdata, paddr, pwdata, prdata;
  logic         rsp_error, pwrite, psel, penable, pready, pslverr;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];

  logic        tie_high, err_val, chk_reset, end_chk, rearm0;
  int          wait_states, acc_cnt, main_err;
  logic [31:0] rdata_val;
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, last_setup = 0, acc_run = 0, cur_acc = 0;

  apb_master_arb #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .NUM_REQ(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completer model: wait_states low cycles in ACCESS, HANG_ADDR never ready
  assign pready  = tie_high | (psel & penable & (paddr != HANG_ADDR) & (acc_cnt >= wait_states));
  assign prdata  = rdata_val;
  assign pslverr = err_val;
  always @(posedge clk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: reset checks, SETUP/ACCESS checks and response scoreboard
  always @(negedge clk) begin
    apb_exp_t ea;
    rsp_exp_t er;
    cyc++;
    if (chk_reset) begin
      chk("reset_apb", 128'({psel, penable, pwrite, paddr, pwdata, pstrb, pprot}), 128'(0));
      chk("reset_rsp", 128'({rsp_valid, rsp_rdata, rsp_error}), 128'(0));
      chk("reset_req_ready", 128'(req_ready), 128'(0));
    end
    if (end_chk) begin
      chk("sb_apb_left", 128'(apb_q.size()), 128'(0));
      chk("sb_rsp_left", 128'(rsp_q.size()), 128'(0));
      chk("bounded_waits", 128'(main_err), 128'(0));
    end
    if (psel === 1'b1) chk("ready_while_busy", 128'(req_ready), 128'(0));
    if (psel === 1'b1 && penable === 1'b1) begin
      acc_run++;
    end else if (acc_run != 0) begin
      if (cur_acc != 0) chk("access_len", 128'(acc_run), 128'(cur_acc));
      acc_run = 0;
    end
    if (psel === 1'b1 && penable === 1'b0) begin
      if (apb_q.size() == 0) begin
        chk("setup_expected", 128'(apb_q.size()), 128'(1));
      end else begin
        ea = apb_q.pop_front();
        chk("setup_fields", 128'({paddr, pwrite, pwdata, pstrb, pprot}),
            128'({ea.addr, ea.wr, ea.wdata, ea.strb, ea.prot}));
        if (ea.gap != 0) chk("setup_gap", 128'(cyc - last_setup), 128'(ea.gap));
        cur_acc = ea.acc;
      end
      last_setup = cyc;
    end
    if (|rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_expected", 128'(rsp_q.size()), 128'(1));
      end else begin
        er = rsp_q.pop_front();
        chk("rsp_valid", 128'(rsp_valid), 128'(4'b0001 << er.idx));
        chk("rsp_rdata", 128'(rsp_rdata), 128'(er.rdata));
        chk("rsp_error", 128'(rsp_error), 128'(er.err));
      end
    end
  end

  task automatic raise(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, input int acc, input int gap,
                       input logic has_rsp, input logic [31:0] exp_rd, input logic exp_err);
    apb_exp_t ea;
    rsp_exp_t er;
    req_write[i]       = w;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]    = s;
    req_prot[i*3 +: 3]    = p;
    req_valid[i]       = 1'b1;
    ea.addr = a; ea.wr = w; ea.wdata = d; ea.strb = w ? s : 4'h0;
    ea.prot = p; ea.acc = acc; ea.gap = gap;
    apb_q.push_back(ea);
    if (has_rsp) begin
      er.idx = i; er.rdata = exp_rd; er.err = exp_err;
      rsp_q.push_back(er);
    end
  endtask

  // One clock: drop accepted requests; requester 0 re-requests once on its response
  task automatic step();
    logic [3:0] rdy, rv;
    @(negedge clk);
    rdy = req_ready;
    rv  = rsp_valid;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~rdy;
    if (rearm0 && rv[0]) begin
      rearm0 = 1'b0;
      raise(0, 1'b0, 32'h110, 32'h5555_0000, 4'hF, 3'd5, 1, 3, 1'b1, 32'h1234_5678, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 chk_reset = 1'b1;
    @(negedge clk); #1 chk_reset = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((apb_q.size() != 0 || rsp_q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) main_err++;
    repeat (3) step();
    @(posedge clk); #1 end_chk = 1'b1;
    @(negedge clk); #1 end_chk = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rstn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; tie_high = 1'b0; err_val = 1'b0; wait_states = 0;
    rdata_val = 32'h1234_5678; chk_reset = 1'b0; end_chk = 1'b0; rearm0 = 1'b1; main_err = 0;

    // All four requesters pending from reset: grants 0,1,2,3,0 with 3-cycle spacing
    raise(0, 1'b1, 32'h100, 32'h1111_0000, 4'h3, 3'd1, 1, 0, 1'b1, 32'h0,         1'b0);
    raise(1, 1'b0, 32'h104, 32'h2222_0000, 4'hF, 3'd2, 1, 3, 1'b1, 32'h1234_5678, 1'b0);
    raise(2, 1'b1, 32'h108, 32'h3333_0000, 4'hC, 3'd3, 1, 3, 1'b1, 32'h0,         1'b0);
    raise(3, 1'b0, 32'h10C, 32'h4444_0000, 4'h1, 3'd4, 1, 3, 1'b1, 32'h1234_5678, 1'b0);
    do_reset();
    drain();

    // Single write from requester 2, pready tied high (also during SETUP)
    tie_high = 1'b1;
    raise(2, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'd0, 1, 0, 1'b1, 32'h0, 1'b0);
    drain();
    tie_high = 1'b0;

    // Read with 3 wait states
    wait_states = 3; rdata_val = 32'hDEAD_BEEF;
    raise(1, 1'b0, 32'h20, 32'h0BAD_F00D, 4'hF, 3'd2, 4, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    drain();
    wait_states = 0;

    // Write answered with PSLVERR
    err_val = 1'b1; rdata_val = 32'hFFFF_0000;
    raise(3, 1'b1, 32'h30, 32'hCAFE_0003, 4'h5, 3'd6, 1, 0, 1'b1, 32'h0, 1'b1);
    drain();
    err_val = 1'b0;

    // Timeout on requester 0, then pending requester 2 served
    rdata_val = 32'h0600_0D00;
    raise(0, 1'b1, HANG_ADDR, 32'h7777_0000, 4'hF, 3'd7, 16, 0, 1'b1, 32'h0, 1'b1);
    raise(2, 1'b0, 32'h40, 32'h0, 4'h0, 3'd1, 1, 18, 1'b1, 32'h0600_0D00, 1'b0);
    drain();

    // Reset in ACCESS: transfer dropped silently, requester 0 wins afterwards
    raise(1, 1'b0, HANG_ADDR, 32'h0, 4'h0, 3'd3, 0, 0, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) main_err++;
    repeat (3) step();
    do_reset();
    raise(0, 1'b1, 32'h50, 32'h5050_5050, 4'hF, 3'd0, 1, 0, 1'b1, 32'h0, 1'b0);
    raise(2, 1'b1, 32'h54, 32'h5454_5454, 4'h3, 3'd0, 1, 3, 1'b1, 32'h0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
